// File: rtl/rs_dsp_seq_pkg.sv
// Shared widths, DSP feedback encoding, sequencer states and the per-vector DSP configuration.
package rs_dsp_seq_pkg;

    localparam int unsigned A_W   = 20;
    localparam int unsigned B_W   = 18;
    localparam int unsigned Z_W   = 38;
    localparam int unsigned SHR_W = 6;

    // Feedback select that makes the DSP add the new product into its own accumulator.
    localparam logic [2:0] FB_ACC = 3'b000;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDrain,
        StHold
    } seq_state_t;

    typedef struct packed {
        logic             unsigned_a;
        logic             unsigned_b;
        logic [SHR_W-1:0] shift_right;
        logic             round;
        logic             saturate;
        logic             subtract;
    } dsp_cfg_t;

endpackage

// File: rtl/rs_dsp_macc_sequencer_if.sv
// Operand beat stream in and dot-product result out, between the vector engine and the sequencer.
interface rs_dsp_macc_sequencer_if #(
    parameter int unsigned MAX_LEN = 1024
) ();
    import rs_dsp_seq_pkg::*;

    localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);

    logic             s_valid;
    logic             s_ready;
    logic [A_W-1:0]   s_a;
    logic [B_W-1:0]   s_b;
    logic             s_last;
    logic             cfg_unsigned_a;
    logic             cfg_unsigned_b;
    logic [SHR_W-1:0] cfg_shift_right;
    logic             cfg_round;
    logic             cfg_saturate;
    logic             cfg_subtract;
    logic             m_valid;
    logic             m_ready;
    logic [Z_W-1:0]   m_z;
    logic [CNT_W-1:0] m_count;
    logic             m_len_err;

    // Engine side: produces beats and consumes results.
    modport master (
        output s_valid, s_a, s_b, s_last,
        output cfg_unsigned_a, cfg_unsigned_b, cfg_shift_right, cfg_round, cfg_saturate,
        output cfg_subtract, m_ready,
        input  s_ready, m_valid, m_z, m_count, m_len_err
    );

    // Sequencer side.
    modport slave (
        input  s_valid, s_a, s_b, s_last,
        input  cfg_unsigned_a, cfg_unsigned_b, cfg_shift_right, cfg_round, cfg_saturate,
        input  cfg_subtract, m_ready,
        output s_ready, m_valid, m_z, m_count, m_len_err
    );

endinterface

// File: rtl/rs_dsp_seq_cfg_reg.sv
// Holds the DSP configuration for the vector in flight; the first beat sees its own cfg at once.
module rs_dsp_seq_cfg_reg
    import rs_dsp_seq_pkg::*;
(
    input  logic     clk,
    input  logic     lreset,
    input  logic     first_beat,
    input  dsp_cfg_t cfg_in,
    output dsp_cfg_t cfg_out
);

    dsp_cfg_t cfg_q;

    // Capture configuration only on the accepted first beat of a vector.
    always_ff @(posedge clk) begin
        if (lreset) begin
            cfg_q <= '0;
        end else if (first_beat) begin
            cfg_q <= cfg_in;
        end
    end

    // The DSP consumes the first product in the same cycle, so bypass the register then.
    assign cfg_out = first_beat ? cfg_in : cfg_q;

endmodule

// File: rtl/rs_dsp_macc_sequencer.sv
// Sequences a MULTIPLY_ACCUMULATE DSP through one dot product per operand vector.
module rs_dsp_macc_sequencer
    import rs_dsp_seq_pkg::*;
#(
    parameter int unsigned ACC_LATENCY = 1,
    parameter int unsigned MAX_LEN     = 1024
) (
    input  logic                   clk,
    input  logic                   lreset,
    rs_dsp_macc_sequencer_if.slave bus,
    output logic [A_W-1:0]         dsp_a,
    output logic [B_W-1:0]         dsp_b,
    output logic                   dsp_load_acc,
    output logic [2:0]             dsp_feedback,
    output logic                   dsp_unsigned_a,
    output logic                   dsp_unsigned_b,
    output logic                   dsp_round,
    output logic                   dsp_saturate,
    output logic                   dsp_subtract,
    output logic [SHR_W-1:0]       dsp_shift_right,
    input  logic [Z_W-1:0]         dsp_z
);

    localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);
    localparam int unsigned DRAIN_W = 2;

    seq_state_t         state_q;
    logic [CNT_W-1:0]   count_q;
    logic [DRAIN_W-1:0] drain_q;
    logic               m_valid_q;
    logic [Z_W-1:0]     m_z_q;
    logic [CNT_W-1:0]   m_count_q;
    logic               len_err_q;

    logic     s_ready;
    logic     accept;
    logic     first_beat;
    dsp_cfg_t cfg_in;
    dsp_cfg_t cfg_out;

    assign s_ready    = (state_q == StIdle) || (state_q == StAccum);
    assign accept     = bus.s_valid & s_ready;
    assign first_beat = accept & (state_q == StIdle);

    assign cfg_in = '{
        unsigned_a:  bus.cfg_unsigned_a,
        unsigned_b:  bus.cfg_unsigned_b,
        shift_right: bus.cfg_shift_right,
        round:       bus.cfg_round,
        saturate:    bus.cfg_saturate,
        subtract:    bus.cfg_subtract
    };

    rs_dsp_seq_cfg_reg u_cfg_reg (
        .clk        (clk),
        .lreset     (lreset),
        .first_beat (first_beat),
        .cfg_in     (cfg_in),
        .cfg_out    (cfg_out)
    );

    // Beat counting, accumulator drain wait and result capture/handshake.
    always_ff @(posedge clk) begin
        if (lreset) begin
            state_q   <= StIdle;
            count_q   <= '0;
            drain_q   <= '0;
            m_valid_q <= 1'b0;
            m_z_q     <= '0;
            m_count_q <= '0;
            len_err_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        count_q   <= CNT_W'(1);
                        len_err_q <= 1'b0;
                        if (bus.s_last) begin
                            drain_q <= DRAIN_W'(ACC_LATENCY - 1);
                            state_q <= StDrain;
                        end else begin
                            state_q <= StAccum;
                        end
                    end
                end
                StAccum: begin
                    if (accept) begin
                        // Saturate the count; beats past the limit still reach the DSP.
                        if (count_q == CNT_W'(MAX_LEN)) begin
                            len_err_q <= 1'b1;
                        end else begin
                            count_q <= count_q + CNT_W'(1);
                        end
                        if (bus.s_last) begin
                            drain_q <= DRAIN_W'(ACC_LATENCY - 1);
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (drain_q == '0) begin
                        m_z_q     <= dsp_z;
                        m_count_q <= count_q;
                        m_valid_q <= 1'b1;
                        state_q   <= StHold;
                    end else begin
                        drain_q <= drain_q - DRAIN_W'(1);
                    end
                end
                StHold: begin
                    if (bus.m_ready) begin
                        m_valid_q <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.s_ready   = s_ready;
    assign bus.m_valid   = m_valid_q;
    assign bus.m_z       = m_z_q;
    assign bus.m_count   = m_count_q;
    assign bus.m_len_err = len_err_q;

    // Zero operands outside accepted beats so the accumulator holds through gaps.
    assign dsp_a        = accept ? bus.s_a : '0;
    assign dsp_b        = accept ? bus.s_b : '0;
    assign dsp_load_acc = first_beat;
    assign dsp_feedback = FB_ACC;

    assign dsp_unsigned_a  = cfg_out.unsigned_a;
    assign dsp_unsigned_b  = cfg_out.unsigned_b;
    assign dsp_shift_right = cfg_out.shift_right;
    assign dsp_round       = cfg_out.round;
    assign dsp_saturate    = cfg_out.saturate;
    assign dsp_subtract    = cfg_out.subtract;

endmodule

// File: tb/tb_rs_dsp_macc_sequencer.sv
// Bench for the MACC sequencer: two instances (default sizing, and short MAX_LEN with a slower
// accumulator), each driving a small behavioural DSP; results checked against a dot-product model.
`timescale 1ns/1ps
module tb_rs_dsp_macc_sequencer;
    import rs_dsp_seq_pkg::*;

    localparam int unsigned LAT_A    = 1;
    localparam int unsigned LAT_B    = 3;
    localparam int unsigned MAXLEN_A = 1024;
    localparam int unsigned MAXLEN_B = 4;

    logic clk = 1'b0;
    logic lreset = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Common stimulus, steered to instance A (sel=0) or B (sel=1).
    logic        sel = 1'b0;
    logic        drv_valid = 1'b0;
    logic        drv_last = 1'b0;
    logic        drv_ready = 1'b0;
    logic [19:0] drv_a = '0;
    logic [17:0] drv_b = '0;
    dsp_cfg_t    drv_cfg = '0;

    rs_dsp_macc_sequencer_if #(.MAX_LEN(MAXLEN_A)) ifa ();
    rs_dsp_macc_sequencer_if #(.MAX_LEN(MAXLEN_B)) ifb ();

    assign ifa.s_valid         = drv_valid & ~sel;
    assign ifb.s_valid         = drv_valid & sel;
    assign ifa.m_ready         = drv_ready & ~sel;
    assign ifb.m_ready         = drv_ready & sel;
    assign ifa.s_a             = drv_a;
    assign ifb.s_a             = drv_a;
    assign ifa.s_b             = drv_b;
    assign ifb.s_b             = drv_b;
    assign ifa.s_last          = drv_last;
    assign ifb.s_last          = drv_last;
    assign ifa.cfg_unsigned_a  = drv_cfg.unsigned_a;
    assign ifb.cfg_unsigned_a  = drv_cfg.unsigned_a;
    assign ifa.cfg_unsigned_b  = drv_cfg.unsigned_b;
    assign ifb.cfg_unsigned_b  = drv_cfg.unsigned_b;
    assign ifa.cfg_shift_right = drv_cfg.shift_right;
    assign ifb.cfg_shift_right = drv_cfg.shift_right;
    assign ifa.cfg_round       = drv_cfg.round;
    assign ifb.cfg_round       = drv_cfg.round;
    assign ifa.cfg_saturate    = drv_cfg.saturate;
    assign ifb.cfg_saturate    = drv_cfg.saturate;
    assign ifa.cfg_subtract    = drv_cfg.subtract;
    assign ifb.cfg_subtract    = drv_cfg.subtract;

    logic [19:0] a_dsp_a, b_dsp_a;
    logic [17:0] a_dsp_b, b_dsp_b;
    logic        a_load, b_load, a_ua, b_ua, a_ub, b_ub, a_rnd, b_rnd, a_sat, b_sat, a_sub, b_sub;
    logic [2:0]  a_fb, b_fb;
    logic [5:0]  a_shr, b_shr;
    logic [37:0] a_z, b_z;

    rs_dsp_macc_sequencer #(.ACC_LATENCY(LAT_A), .MAX_LEN(MAXLEN_A)) dut_a (
        .clk(clk), .lreset(lreset), .bus(ifa),
        .dsp_a(a_dsp_a), .dsp_b(a_dsp_b), .dsp_load_acc(a_load), .dsp_feedback(a_fb),
        .dsp_unsigned_a(a_ua), .dsp_unsigned_b(a_ub), .dsp_round(a_rnd), .dsp_saturate(a_sat),
        .dsp_subtract(a_sub), .dsp_shift_right(a_shr), .dsp_z(a_z)
    );

    rs_dsp_macc_sequencer #(.ACC_LATENCY(LAT_B), .MAX_LEN(MAXLEN_B)) dut_b (
        .clk(clk), .lreset(lreset), .bus(ifb),
        .dsp_a(b_dsp_a), .dsp_b(b_dsp_b), .dsp_load_acc(b_load), .dsp_feedback(b_fb),
        .dsp_unsigned_a(b_ua), .dsp_unsigned_b(b_ub), .dsp_round(b_rnd), .dsp_saturate(b_sat),
        .dsp_subtract(b_sub), .dsp_shift_right(b_shr), .dsp_z(b_z)
    );

    // Signed/unsigned 20x18 product, negated when subtracting, reduced mod 2^38.
    function automatic logic [37:0] prod(input logic [19:0] a, input logic [17:0] b,
                                         input logic ua, input logic ub, input logic sub);
        logic [63:0] av, bv, p;
        av = ua ? {44'd0, a} : {{44{a[19]}}, a};
        bv = ub ? {46'd0, b} : {{46{b[17]}}, b};
        p  = av * bv;
        if (sub) p = -p;
        return p[37:0];
    endfunction

    // Behavioural DSPs: accumulator register, plus extra output stages for instance B.
    logic [37:0] acc_a, acc_b, pipe_b1, pipe_b2;
    always @(posedge clk) begin
        if (lreset) acc_a <= '0;
        else if (a_load) acc_a <= prod(a_dsp_a, a_dsp_b, a_ua, a_ub, a_sub);
        else acc_a <= acc_a + prod(a_dsp_a, a_dsp_b, a_ua, a_ub, a_sub);
    end
    always @(posedge clk) begin
        if (lreset) begin
            acc_b <= '0; pipe_b1 <= '0; pipe_b2 <= '0;
        end else begin
            if (b_load) acc_b <= prod(b_dsp_a, b_dsp_b, b_ua, b_ub, b_sub);
            else acc_b <= acc_b + prod(b_dsp_a, b_dsp_b, b_ua, b_ub, b_sub);
            pipe_b1 <= acc_b;
            pipe_b2 <= pipe_b1;
        end
    end
    assign a_z = acc_a;
    assign b_z = pipe_b2;

    // Observed view of the selected instance.
    logic        o_s_ready, o_m_valid, o_len_err, o_load;
    logic [37:0] o_m_z;
    logic [10:0] o_m_count;
    logic [19:0] o_dsp_a;
    logic [17:0] o_dsp_b;
    logic [2:0]  o_fb;
    dsp_cfg_t    o_cfg;
    always_comb begin
        if (sel) begin
            o_s_ready = ifb.s_ready; o_m_valid = ifb.m_valid; o_len_err = ifb.m_len_err;
            o_m_z = ifb.m_z; o_m_count = 11'(ifb.m_count); o_load = b_load;
            o_dsp_a = b_dsp_a; o_dsp_b = b_dsp_b; o_fb = b_fb;
            o_cfg = '{unsigned_a: b_ua, unsigned_b: b_ub, shift_right: b_shr, round: b_rnd,
                      saturate: b_sat, subtract: b_sub};
        end else begin
            o_s_ready = ifa.s_ready; o_m_valid = ifa.m_valid; o_len_err = ifa.m_len_err;
            o_m_z = ifa.m_z; o_m_count = ifa.m_count; o_load = a_load;
            o_dsp_a = a_dsp_a; o_dsp_b = a_dsp_b; o_fb = a_fb;
            o_cfg = '{unsigned_a: a_ua, unsigned_b: a_ub, shift_right: a_shr, round: a_rnd,
                      saturate: a_sat, subtract: a_sub};
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic [19:0] qa[$];
    logic [17:0] qb[$];
    int          qgap[$];
    logic [37:0] got_z;
    logic [10:0] got_cnt;
    logic        got_err;

    task automatic add_beat(input logic [19:0] a, input logic [17:0] b, input int gap);
        qa.push_back(a); qb.push_back(b); qgap.push_back(gap);
    endtask

    task automatic clear_beats();
        qa.delete(); qb.delete(); qgap.delete();
    endtask

    // Send the queued beats with cfg on the first beat and 'later' on the rest, then collect.
    task automatic run_vector(input dsp_cfg_t cfg, input dsp_cfg_t later, input int hold);
        logic [37:0] ez;
        int n, cnt, maxlen, lat, edges;
        logic eerr;
        n = qa.size();
        maxlen = sel ? MAXLEN_B : MAXLEN_A;
        lat = sel ? LAT_B : LAT_A;
        ez = '0;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < qgap[i]; g++) begin
                @(negedge clk);
                drv_valid = 1'b0; drv_a = 20'($urandom); drv_b = 18'($urandom);
                drv_last = 1'($urandom);
                #1;
                check("gap_dsp_a", 64'(o_dsp_a), 64'd0);
                check("gap_dsp_b", 64'(o_dsp_b), 64'd0);
                check("gap_load_acc", 64'(o_load), 64'd0);
            end
            @(negedge clk);
            check("s_ready_beat", 64'(o_s_ready), 64'd1);
            drv_valid = 1'b1; drv_a = qa[i]; drv_b = qb[i]; drv_last = (i == n - 1);
            drv_cfg = (i == 0) ? cfg : later;
            #1;
            check("dsp_a", 64'(o_dsp_a), 64'(qa[i]));
            check("dsp_b", 64'(o_dsp_b), 64'(qb[i]));
            check("load_acc", 64'(o_load), 64'(i == 0));
            check("cfg_pins", {53'd0, o_cfg}, {53'd0, cfg});
            check("feedback", 64'(o_fb), 64'd0);
            ez = ez + prod(qa[i], qb[i], cfg.unsigned_a, cfg.unsigned_b, cfg.subtract);
        end
        cnt  = (n < maxlen) ? n : maxlen;
        eerr = (n > maxlen);
        @(negedge clk);
        drv_valid = 1'b0; drv_a = 20'($urandom); drv_b = 18'($urandom);
        edges = 1;
        while (!o_m_valid && edges < 20) begin
            check("s_ready_drain", 64'(o_s_ready), 64'd0);
            @(negedge clk);
            edges++;
        end
        check("latency", 64'(edges - 1), 64'(lat));
        got_z = o_m_z; got_cnt = o_m_count; got_err = o_len_err;
        check("m_z", 64'(o_m_z), 64'(ez));
        check("m_count", 64'(o_m_count), 64'(cnt));
        check("m_len_err", 64'(o_len_err), 64'(eerr));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 64'(o_m_valid), 64'd1);
            check("hold_z", 64'(o_m_z), 64'(ez));
            check("hold_count", 64'(o_m_count), 64'(cnt));
            check("hold_len_err", 64'(o_len_err), 64'(eerr));
            check("hold_s_ready", 64'(o_s_ready), 64'd0);
        end
        drv_ready = 1'b1;
        @(negedge clk);
        drv_ready = 1'b0;
        check("release_valid", 64'(o_m_valid), 64'd0);
        check("release_s_ready", 64'(o_s_ready), 64'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        drv_valid = 1'b0; drv_ready = 1'b0; lreset = 1'b1;
        @(negedge clk);
        lreset = 1'b0;
        #1;
        check("rst_m_valid", 64'(o_m_valid), 64'd0);
        check("rst_m_z", 64'(o_m_z), 64'd0);
        check("rst_m_count", 64'(o_m_count), 64'd0);
        check("rst_len_err", 64'(o_len_err), 64'd0);
        check("rst_cfg", {53'd0, o_cfg}, 64'd0);
        check("rst_s_ready", 64'(o_s_ready), 64'd1);
    endtask

    task automatic rand_vector(input int maxn);
        int n;
        dsp_cfg_t c, l;
        n = $urandom_range(maxn, 1);
        clear_beats();
        for (int i = 0; i < n; i++)
            add_beat(20'($urandom), 18'($urandom), ($urandom_range(2, 0) == 0) ? 2 : 0);
        c = dsp_cfg_t'(11'($urandom));
        l = dsp_cfg_t'(11'($urandom));
        run_vector(c, l, $urandom_range(3, 0));
    endtask

    initial begin
        dsp_cfg_t c0, cu, c3;
        c0 = '0;
        cu = '0; cu.unsigned_a = 1'b1; cu.unsigned_b = 1'b1;
        c3 = '0; c3.shift_right = 6'd3;
        do_reset();

        clear_beats(); add_beat(20'd3, 18'd4, 0); add_beat(20'd5, 18'd6, 0);
        run_vector(cu, cu, 0);
        check("unsigned_z", 64'(got_z), 64'd42);
        check("unsigned_count", 64'(got_cnt), 64'd2);

        clear_beats(); add_beat(20'hFFFFE, 18'd7, 0);
        run_vector(c0, c0, 0);
        check("signed_z", 64'(got_z), 64'h3F_FFFF_FFF2);
        check("signed_count", 64'(got_cnt), 64'd1);

        clear_beats(); add_beat(20'd3, 18'd4, 0); add_beat(20'd5, 18'd6, 3);
        run_vector(c0, c0, 0);
        check("gap_z", 64'(got_z), 64'd42);

        clear_beats(); add_beat(20'd9, 18'd10, 0); add_beat(20'd11, 18'd2, 1);
        run_vector(cu, c3, 5);
        check("bp_z", 64'(got_z), 64'd112);

        // Reset in the middle of a vector discards it.
        @(negedge clk);
        drv_valid = 1'b1; drv_a = 20'd7; drv_b = 18'd9; drv_last = 1'b0; drv_cfg = cu;
        @(negedge clk);
        drv_a = 20'd1; drv_b = 18'd1;
        do_reset();
        clear_beats(); add_beat(20'd2, 18'd2, 0);
        run_vector(c0, c0, 0);
        check("rst_vec_z", 64'(got_z), 64'd4);
        check("rst_vec_count", 64'(got_cnt), 64'd1);

        // Short MAX_LEN instance: overflow and ignored mid-vector config change.
        @(negedge clk);
        sel = 1'b1;
        clear_beats();
        for (int i = 0; i < 6; i++) add_beat(20'd1, 18'd1, 0);
        run_vector(c0, c3, 1);
        check("ovf_count", 64'(got_cnt), 64'd4);
        check("ovf_len_err", 64'(got_err), 64'd1);
        check("ovf_z", 64'(got_z), 64'd6);
        check("ovf_shift_pin", 64'(o_cfg.shift_right), 64'd0);

        for (int v = 0; v < 15; v++) rand_vector(7);

        @(negedge clk);
        sel = 1'b0;
        for (int v = 0; v < 25; v++) rand_vector(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rs_dsp_macc_sequencer.md
Name: rs_dsp_macc_sequencer

Overview:
Controller that sequences one MULTIPLY_ACCUMULATE DSP38 instance (unregistered inputs/outputs) to compute dot products. It accepts a stream of (a, b) operand beats terminated by a last flag and drives the DSP control pins: load_acc on the first beat, zero operands when idle, and a per-vector configuration. It waits out the accumulator latency, then returns the 38-bit result through a valid/ready handshake. Sits between a vector-producing engine and the DSP primitive wrapper.

Parameters:
ACC_LATENCY, 1, cycles from last accepted beat's edge until dsp_z holds the final accumulated value (1..4)
MAX_LEN, 1024, maximum beats per vector; beat count saturates here
CNT_W, $clog2(MAX_LEN+1), width of the beat counter (derived, not overridden)

Ports:
clk  in  1  clock
lreset  in  1  synchronous active-high reset
s_valid  in  1  operand beat valid
s_ready  out  1  operand beat accepted when s_valid&s_ready
s_a  in  20  multiplicand
s_b  in  18  multiplier
s_last  in  1  final beat of vector
cfg_unsigned_a  in  1  latched on first beat
cfg_unsigned_b  in  1  latched on first beat
cfg_shift_right  in  6  latched on first beat
cfg_round  in  1  latched on first beat
cfg_saturate  in  1  latched on first beat
cfg_subtract  in  1  latched on first beat
dsp_a  out  20  to DSP A
dsp_b  out  18  to DSP B
dsp_load_acc  out  1  to DSP LOAD_ACC
dsp_feedback  out  3  to DSP FEEDBACK, constant FB_ACC
dsp_unsigned_a, dsp_unsigned_b, dsp_round, dsp_saturate, dsp_subtract  out  1 each  latched config
dsp_shift_right  out  6  latched config
dsp_z  in  38  DSP Z
m_valid  out  1  result valid
m_ready  in  1  result consumed
m_z  out  38  registered result
m_count  out  CNT_W  beats in vector
m_len_err  out  1  vector exceeded MAX_LEN

Behaviour:
- Clock clk; reset lreset is synchronous, active-high.
- States: IDLE, ACCUM, DRAIN, HOLD.
- Reset: state IDLE, m_valid=0, m_z=0, m_count=0, m_len_err=0, latched config=0, drain counter=0. Reset takes effect on any state, including mid-vector and in HOLD; any partial result is discarded. The DSP shares lreset and clears itself.
- s_ready = 1 in IDLE and ACCUM, 0 in DRAIN and HOLD.
- dsp_a/dsp_b are combinational: s_a/s_b when s_valid&s_ready, else 0. A zero product holds the accumulator during gaps.
- dsp_load_acc = s_valid&s_ready&(state==IDLE). It is combinational and asserts only on the first beat.
- dsp_feedback = FB_ACC always.
- IDLE:
  - On beat: latch cfg_*, set count=1, clear err.
  - If s_last, go DRAIN; else go ACCUM.
  - On the first beat, dsp_* config pins take the cfg_* inputs directly (bypass), then use the latched values.
- ACCUM:
  - Each beat increments count, saturating at MAX_LEN.
  - A beat arriving with count==MAX_LEN sets m_len_err.
  - s_last beat moves to DRAIN.
- DRAIN: counter loads ACC_LATENCY-1 on entry and decrements. At 0, capture dsp_z into m_z and count into m_count, set m_valid=1, go HOLD.
- Latency: with ACC_LATENCY=1, the last beat is accepted at edge E and m_valid rises at edge E+1.
- HOLD: m_z, m_count and m_len_err are stable while m_valid & !m_ready. On m_ready, clear m_valid at that edge and go IDLE. A new vector's first beat is accepted from the following cycle.
- Config changes on cfg_* mid-vector are ignored.
- Arithmetic (sign, shift, round, saturate) is performed by the DSP; the sequencer passes it through unchanged.

Decomposition:
- Package rs_dsp_seq_pkg:
  - widths A_W=20, B_W=18, Z_W=38, SHR_W=6
  - FB_ACC=3'b000
  - state enum seq_state_t
  - packed struct dsp_cfg_t {unsigned_a, unsigned_b, shift_right, round, saturate, subtract}
- One natural sub-module: rs_dsp_seq_cfg_reg. It latches dsp_cfg_t on first beat and provides the first-beat bypass mux.

Test Plan:
- Unsigned: beats (3,4),(5,6,last), cfg all 0 except unsigned_a=unsigned_b=1 → load_acc high only on beat 1; m_z=42, m_count=2, m_valid 2 edges after last.
- Signed single beat: a=20'hFFFFE, b=7, last, unsigned=0 → DRAIN entered directly; m_z=38'h3F_FFFF_FFF2, m_count=1.
- Gaps: (3,4), 3 idle cycles, (5,6,last) → dsp_a/dsp_b=0 during gaps; m_z=42.
- Backpressure: m_ready low 5 cycles after m_valid → m_z/m_count stable, s_ready=0 throughout; 1-cycle m_ready pulse → m_valid=0 next edge, s_ready=1.
- Reset mid-vector: 2 beats, then lreset for 1 cycle, then (2,2,last) → all outputs at reset values after reset; m_z=4, m_count=1.
- Overflow: MAX_LEN=4 override, 6 beats of (1,1) → m_count=4, m_len_err=1. Config change mid-vector (shift_right 0→3) → dsp_shift_right stays 0.
